// File: rtl/detector_jogada.sv
// detector_jogada: push-button input stage for the game control FSM.
// Two-flop synchroniser, per-bit counter debounce and a press/release FSM
// producing tem_jogada / solto pulses and the captured jogada code.
// Optional feature macro: DETECTOR_JOGADA_REJEITA_MULTIPLO_EN
// (when defined, multi-button presses are not accepted as plays).
module detector_jogada #(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                zera_jogada,
  output logic                tem_jogada,
  output logic                tem_botao_pressionado,
  output logic [N_BOTOES-1:0] jogada,
  output logic                solto,
  output logic [1:0]          db_estado
);

  // DEBOUNCE_CYCLES == 1 would give a zero-width counter; keep at least one bit.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    PULSO       = 2'd1,
    PRESSIONADO = 2'd2,
    LIBERADO    = 2'd3
  } estado_t;

  logic [N_BOTOES-1:0] r_sinc1;
  logic [N_BOTOES-1:0] r_sinc2;
  logic [N_BOTOES-1:0] r_estavel;
  logic [CW-1:0]       r_cnt [N_BOTOES];
  logic [N_BOTOES-1:0] r_jogada;
  estado_t             r_estado;

`ifdef DETECTOR_JOGADA_REJEITA_MULTIPLO_EN
  logic w_multiplo;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign w_multiplo = |(r_estavel & (r_estavel - 1'b1));
`endif

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sinc1 <= '0;
      r_sinc2 <= '0;
    end else begin
      r_sinc1 <= botoes;
      r_sinc2 <= r_sinc1;
    end
  end

  // Per-bit debounce: flip only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estavel <= '0;
      for (int unsigned i = 0; i < N_BOTOES; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_BOTOES; i++) begin
        if (r_sinc2[i] == r_estavel[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_estavel[i] <= ~r_estavel[i];
          r_cnt[i]     <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press/release FSM with jogada capture; zera_jogada overrides a capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= OCIOSO;
      r_jogada <= '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (r_estavel != '0) begin
`ifdef DETECTOR_JOGADA_REJEITA_MULTIPLO_EN
            if (w_multiplo) begin
              r_estado <= PRESSIONADO;
            end else begin
              r_estado <= PULSO;
              r_jogada <= r_estavel;
            end
`else
            r_estado <= PULSO;
            r_jogada <= r_estavel;
`endif
          end
        end
        PULSO:       r_estado <= PRESSIONADO;
        PRESSIONADO: if (r_estavel == '0) r_estado <= LIBERADO;
        LIBERADO:    r_estado <= OCIOSO;
        default:     r_estado <= OCIOSO;
      endcase
      if (zera_jogada) r_jogada <= '0;
    end
  end

  // Moore outputs decoded from the state register.
  assign tem_jogada            = (r_estado == PULSO);
  assign solto                 = (r_estado == LIBERADO);
  assign tem_botao_pressionado = |r_estavel;
  assign jogada                = r_jogada;
  assign db_estado             = r_estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with N_BOTOES=4, DEBOUNCE_CYCLES=4.
module tb_detector_jogada;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] botoes = '0;
  logic       zera_jogada = 1'b0;
  logic       tem_jogada;
  logic       tem_botao_pressionado;
  logic [3:0] jogada;
  logic       solto;
  logic [1:0] db_estado;

  int checks = 0;
  int errors = 0;
  int n_pulse = 0;
  int n_solto = 0;

  detector_jogada #(.N_BOTOES(4), .DEBOUNCE_CYCLES(4)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .botoes                (botoes),
    .zera_jogada           (zera_jogada),
    .tem_jogada            (tem_jogada),
    .tem_botao_pressionado (tem_botao_pressionado),
    .jogada                (jogada),
    .solto                 (solto),
    .db_estado             (db_estado)
  );

  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge, counting output pulses.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      if (tem_jogada) n_pulse++;
      if (solto) n_solto++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(3);
    checks++;
    if ({tem_jogada, tem_botao_pressionado, jogada, solto, db_estado} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 000000000",
               {tem_jogada, tem_botao_pressionado, jogada, solto, db_estado});
    end
    reset = 1'b1;
    tick(2);
    checks++;
    if (db_estado !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle_state: got %0d required 0", db_estado);
    end
  endtask

  task automatic test_clean_press;
    n_pulse = 0; n_solto = 0;
    botoes = 4'b0100;
    tick(5);
    checks++;
    if (tem_botao_pressionado !== 1'b0) begin
      errors++; $display("FAIL press_tbp_edge5: got %b required 0", tem_botao_pressionado);
    end
    tick(1);
    checks++;
    if (tem_botao_pressionado !== 1'b1 || tem_jogada !== 1'b0) begin
      errors++; $display("FAIL press_edge6: tbp %b tem_jogada %b required 1 0", tem_botao_pressionado, tem_jogada);
    end
    tick(1);
    checks++;
    if (tem_jogada !== 1'b1 || jogada !== 4'b0100 || db_estado !== 2'd1) begin
      errors++; $display("FAIL press_edge7: tem_jogada %b jogada %b estado %0d required 1 0100 1", tem_jogada, jogada, db_estado);
    end
    tick(1);
    checks++;
    if (tem_jogada !== 1'b0 || db_estado !== 2'd2) begin
      errors++; $display("FAIL press_edge8: tem_jogada %b estado %0d required 0 2", tem_jogada, db_estado);
    end
    tick(12);
    botoes = 4'b0000;
    tick(5);
    checks++;
    if (tem_botao_pressionado !== 1'b1) begin
      errors++; $display("FAIL release_tbp_edge5: got %b required 1", tem_botao_pressionado);
    end
    tick(1);
    checks++;
    if (tem_botao_pressionado !== 1'b0 || solto !== 1'b0) begin
      errors++; $display("FAIL release_edge6: tbp %b solto %b required 0 0", tem_botao_pressionado, solto);
    end
    tick(1);
    checks++;
    if (solto !== 1'b1 || db_estado !== 2'd3) begin
      errors++; $display("FAIL release_edge7: solto %b estado %0d required 1 3", solto, db_estado);
    end
    tick(1);
    checks++;
    if (solto !== 1'b0 || db_estado !== 2'd0) begin
      errors++; $display("FAIL release_edge8: solto %b estado %0d required 0 0", solto, db_estado);
    end
    tick(5);
    checks++;
    if (n_pulse !== 1 || n_solto !== 1 || jogada !== 4'b0100) begin
      errors++; $display("FAIL press_counts: pulses %0d soltos %0d jogada %b required 1 1 0100", n_pulse, n_solto, jogada);
    end
  endtask

  task automatic test_bounce;
    logic [14:0] padrao;
    int seen_tbp;
    padrao = 15'b1_0111_0110_1101_01; // high runs of 1..3 cycles
    n_pulse = 0; n_solto = 0; seen_tbp = 0;
    for (int i = 0; i < 15; i++) begin
      botoes = {3'b000, padrao[i]};
      tick(1);
      if (tem_botao_pressionado) seen_tbp++;
    end
    botoes = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (tem_botao_pressionado) seen_tbp++;
    end
    checks++;
    if (seen_tbp !== 0 || n_pulse !== 0 || n_solto !== 0) begin
      errors++; $display("FAIL bounce: tbp_cycles %0d pulses %0d soltos %0d required 0 0 0", seen_tbp, n_pulse, n_solto);
    end
  endtask

  task automatic test_clear_priority;
    n_pulse = 0;
    botoes = 4'b0010;
    tick(6);
    zera_jogada = 1'b1;
    tick(1);
    zera_jogada = 1'b0;
    checks++;
    if (tem_jogada !== 1'b1 || jogada !== 4'b0000) begin
      errors++; $display("FAIL clear_priority: tem_jogada %b jogada %b required 1 0000", tem_jogada, jogada);
    end
    tick(5);
    botoes = 4'b0000;
    tick(12);
    botoes = 4'b0001;
    tick(10);
    checks++;
    if (jogada !== 4'b0001 || n_pulse !== 2) begin
      errors++; $display("FAIL clear_then_press: jogada %b pulses %0d required 0001 2", jogada, n_pulse);
    end
    botoes = 4'b0000;
    tick(12);
  endtask

  task automatic test_change_while_held;
    n_pulse = 0; n_solto = 0;
    botoes = 4'b0001;
    tick(8);
    checks++;
    if (db_estado !== 2'd2) begin
      errors++; $display("FAIL held_state: got %0d required 2", db_estado);
    end
    botoes = 4'b1001;
    tick(12);
    checks++;
    if (jogada !== 4'b0001 || n_pulse !== 1 || db_estado !== 2'd2) begin
      errors++; $display("FAIL held_change: jogada %b pulses %0d estado %0d required 0001 1 2", jogada, n_pulse, db_estado);
    end
    botoes = 4'b0000;
    tick(12);
    checks++;
    if (n_solto !== 1 || n_pulse !== 1) begin
      errors++; $display("FAIL held_release: soltos %0d pulses %0d required 1 1", n_solto, n_pulse);
    end
  endtask

  task automatic test_chord;
    n_pulse = 0; n_solto = 0;
    botoes = 4'b0011;
    tick(7);
`ifdef DETECTOR_JOGADA_REJEITA_MULTIPLO_EN
    checks++;
    if (tem_jogada !== 1'b0 || db_estado !== 2'd2 || jogada !== 4'b0001) begin
      errors++; $display("FAIL chord_reject: tem_jogada %b estado %0d jogada %b required 0 2 0001", tem_jogada, db_estado, jogada);
    end
`else
    checks++;
    if (tem_jogada !== 1'b1 || jogada !== 4'b0011) begin
      errors++; $display("FAIL chord_accept: tem_jogada %b jogada %b required 1 0011", tem_jogada, jogada);
    end
`endif
    tick(5);
    botoes = 4'b0000;
    tick(12);
    checks++;
`ifdef DETECTOR_JOGADA_REJEITA_MULTIPLO_EN
    if (n_solto !== 1 || n_pulse !== 0) begin
      errors++; $display("FAIL chord_counts: soltos %0d pulses %0d required 1 0", n_solto, n_pulse);
    end
`else
    if (n_solto !== 1 || n_pulse !== 1) begin
      errors++; $display("FAIL chord_counts: soltos %0d pulses %0d required 1 1", n_solto, n_pulse);
    end
`endif
  endtask

  task automatic test_reset_mid_press;
    botoes = 4'b0100;
    tick(7);
    checks++;
    if (tem_jogada !== 1'b1) begin
      errors++; $display("FAIL midreset_pre: tem_jogada %b required 1", tem_jogada);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({tem_jogada, tem_botao_pressionado, jogada, solto, db_estado} !== 9'b0) begin
      errors++; $display("FAIL midreset_outputs: got %b required 000000000",
                         {tem_jogada, tem_botao_pressionado, jogada, solto, db_estado});
    end
    tick(2);
    reset = 1'b1;
    n_pulse = 0;
    tick(6);
    checks++;
    if (tem_jogada !== 1'b0 || n_pulse !== 0) begin
      errors++; $display("FAIL midreset_early: tem_jogada %b pulses %0d required 0 0", tem_jogada, n_pulse);
    end
    tick(1);
    checks++;
    if (tem_jogada !== 1'b1 || jogada !== 4'b0100) begin
      errors++; $display("FAIL midreset_repress: tem_jogada %b jogada %b required 1 0100", tem_jogada, jogada);
    end
    botoes = 4'b0000;
    tick(12);
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_clear_priority;
    test_change_while_held;
    test_chord;
    test_reset_mid_press;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
